// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the pipeline/RAM memory sequencer.
package mem_ctrl_pkg;

  // Request op encoding (3 behaves as NOP)
  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  // Request length encoding (3 behaves as WORD)
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  // Global enable levels
  localparam logic ChipStall    = 1'b0;
  localparam logic ChipNotStall = 1'b1;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of byte cycles for a length code
  function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
    case (len)
      MEM_BYTE: len_bytes = CNT_W'(1);
      MEM_HALF: len_bytes = CNT_W'(2);
      default:  len_bytes = CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF/MEM requests onto a byte-wide synchronous RAM, one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [1:0]        if_op,
  input  logic [1:0]        if_len,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rdy,
  output logic [31:0]       if_out,
  input  logic [1:0]        mem_op,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic              mem_rdy,
  output logic [31:0]       mem_out,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_rw,
  input  logic [7:0]        ram_din
);

  state_t              r_state, w_state_nx;
  logic                r_store, w_store_nx;
  logic                r_gnt_mem, w_gnt_mem_nx;
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;
  logic [DATA_W-1:0]   r_data, w_data_nx;
  logic [CNT_W-1:0]    r_n, w_n_nx;
  logic [CNT_W-1:0]    r_i, w_i_nx;
  logic [1:0]          r_j, w_j_nx;
  logic [DATA_W-1:0]   r_result, w_result_nx;
  logic                r_cap, w_cap_nx;
  logic [7:0]          r_skid;
  logic                r_skid_vld;
  logic [7:0]          w_cap_byte;

  logic                r_if_rdy, w_if_rdy_nx;
  logic [DATA_W-1:0]   r_if_out, w_if_out_nx;
  logic                r_mem_rdy, w_mem_rdy_nx;
  logic [DATA_W-1:0]   r_mem_out, w_mem_out_nx;
  logic [ADDR_W-1:0]   r_ram_a, w_ram_a_nx;
  logic [7:0]          r_ram_dout, w_ram_dout_nx;
  logic                r_ram_rw, w_ram_rw_nx;

  logic                w_mem_req, w_if_req, w_active;

  assign w_mem_req = (mem_op == MEM_LOAD) || (mem_op == MEM_STORE);
  assign w_if_req  = (if_op == MEM_LOAD) || (if_op == MEM_STORE);
  assign w_active  = (rdy_in == ChipNotStall);

  assign if_rdy   = r_if_rdy;
  assign if_out   = r_if_out;
  assign mem_rdy  = r_mem_rdy;
  assign mem_out  = r_mem_out;
  assign ram_a    = r_ram_a;
  assign ram_dout = r_ram_dout;
  // A frozen cycle must never write, even mid-store
  assign ram_rw   = r_ram_rw & w_active;

  // Next-state, byte sequencing, load assembly and completion
  always_comb begin
    w_state_nx    = r_state;
    w_store_nx    = r_store;
    w_gnt_mem_nx  = r_gnt_mem;
    w_addr_nx     = r_addr;
    w_data_nx     = r_data;
    w_n_nx        = r_n;
    w_i_nx        = r_i;
    w_j_nx        = r_j;
    w_result_nx   = r_result;
    w_cap_nx      = 1'b0;
    w_if_rdy_nx   = 1'b0;
    w_if_out_nx   = r_if_out;
    w_mem_rdy_nx  = 1'b0;
    w_mem_out_nx  = r_mem_out;
    w_ram_a_nx    = r_ram_a;
    w_ram_dout_nx = 8'd0;
    w_ram_rw_nx   = 1'b0;
    w_cap_byte    = r_skid_vld ? r_skid : ram_din;

    if (r_cap) begin
      w_result_nx[{r_j, 3'b000} +: 8] = w_cap_byte;
      w_j_nx = r_j + 2'd1;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_mem_req || w_if_req) begin
          w_gnt_mem_nx  = w_mem_req;
          w_store_nx    = w_mem_req ? (mem_op == MEM_STORE) : (if_op == MEM_STORE);
          w_addr_nx     = w_mem_req ? mem_addr : if_addr;
          w_data_nx     = w_mem_req ? mem_data : '0;
          w_n_nx        = len_bytes(w_mem_req ? mem_len : if_len);
          w_result_nx   = '0;
          w_j_nx        = 2'd0;
          w_i_nx        = CNT_W'(1);
          w_ram_a_nx    = w_addr_nx;
          w_ram_rw_nx   = w_store_nx;
          w_ram_dout_nx = w_data_nx[7:0];
          w_state_nx    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cap_nx = ~r_store;
        if (r_i == r_n) begin
          if (r_store) begin
            w_state_nx = ST_DONE;
            if (r_gnt_mem) begin
              w_mem_rdy_nx = 1'b1;
              w_mem_out_nx = '0;
            end else begin
              w_if_rdy_nx = 1'b1;
              w_if_out_nx = '0;
            end
          end else begin
            w_state_nx = ST_DRAIN;
          end
        end else begin
          w_ram_a_nx    = r_addr + ADDR_W'(r_i);
          w_ram_rw_nx   = r_store;
          w_ram_dout_nx = r_data[{r_i[1:0], 3'b000} +: 8];
          w_i_nx        = r_i + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        w_state_nx = ST_DONE;
        if (r_gnt_mem) begin
          w_mem_rdy_nx = 1'b1;
          w_mem_out_nx = w_result_nx;
        end else begin
          w_if_rdy_nx = 1'b1;
          w_if_out_nx = w_result_nx;
        end
      end
      ST_DONE:  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // State register, frozen while stalled
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)        r_state <= ST_IDLE;
    else if (w_active) r_state <= w_state_nx;
  end

  // Datapath and output registers; the RAM keeps reading the held address
  // while frozen, so the byte due on the first frozen cycle is parked in r_skid
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_store    <= 1'b0;
      r_gnt_mem  <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_n        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_result   <= '0;
      r_cap      <= 1'b0;
      r_skid     <= 8'd0;
      r_skid_vld <= 1'b0;
      r_if_rdy   <= 1'b0;
      r_if_out   <= '0;
      r_mem_rdy  <= 1'b0;
      r_mem_out  <= '0;
      r_ram_a    <= '0;
      r_ram_dout <= 8'd0;
      r_ram_rw   <= 1'b0;
    end else if (w_active) begin
      r_store    <= w_store_nx;
      r_gnt_mem  <= w_gnt_mem_nx;
      r_addr     <= w_addr_nx;
      r_data     <= w_data_nx;
      r_n        <= w_n_nx;
      r_i        <= w_i_nx;
      r_j        <= w_j_nx;
      r_result   <= w_result_nx;
      r_cap      <= w_cap_nx;
      r_skid_vld <= 1'b0;
      r_if_rdy   <= w_if_rdy_nx;
      r_if_out   <= w_if_out_nx;
      r_mem_rdy  <= w_mem_rdy_nx;
      r_mem_out  <= w_mem_out_nx;
      r_ram_a    <= w_ram_a_nx;
      r_ram_dout <= w_ram_dout_nx;
      r_ram_rw   <= w_ram_rw_nx;
    end else if (r_cap && !r_skid_vld) begin
      r_skid     <= ram_din;
      r_skid_vld <= 1'b1;
    end
  end

endmodule
